// File: rtl/operand_stage.sv
// operand_stage
//   Two-entry (main + skid) operand holding stage between register-file read
//   and execute. Each entry carries NCH source addresses and NCH data words.
//   Writebacks are forwarded into operands as they are captured and into
//   operands that are already held, so a set never leaves the stage stale.
//
// Ports
//   CLK        clock, rising edge
//   reset      asynchronous, active-low reset
//   flush      synchronous discard of all held sets
//   in_valid   upstream operand set valid
//   in_ready   stage can accept a set (state EMPTY or ONE)
//   rd_addr    per-channel source address, channel k at [k*AW +: AW]
//   rd_data    per-channel register-file data, channel k at [k*WIDTH +: WIDTH]
//   wb_en      writeback valid
//   wb_addr    writeback register address
//   wb_data    writeback data
//   out_valid  operand set presented (state ONE or TWO)
//   out_ready  downstream accepts
//   out_data   main entry data, same packing as rd_data
//   stall_cnt  saturating count of cycles with out_valid & !out_ready

// ---------------------------------------------------------------------------
// operand_lane
//   Storage and forwarding for one operand channel of both entries.
//   The parent supplies one-hot-ish load controls; this module only decides
//   which value lands in each register.
//
// Ports
//   CLK, reset   clock / async active-low reset
//   load_main    main <= incoming operand (with capture forwarding)
//   load_skid    skid <= incoming operand (with capture forwarding)
//   copy_skid    main <= skid (with held forwarding applied to the skid word)
//   main_vld     main entry currently holds a live set
//   skid_vld     skid entry currently holds a live set
//   rd_addr      incoming source address for this channel
//   rd_data      incoming register-file data for this channel
//   wb_hit       wb_en & (wb_addr != 0), computed once in the parent
//   wb_addr      writeback address
//   wb_data      writeback data
//   main_data    current main word for this channel
// ---------------------------------------------------------------------------
module operand_lane #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load_main,
  input  logic             load_skid,
  input  logic             copy_skid,
  input  logic             main_vld,
  input  logic             skid_vld,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             wb_hit,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] main_data
);

  logic [AW-1:0]    main_addr, skid_addr;
  logic [WIDTH-1:0] main_q, skid_q;

  logic             cap_hit, main_hit, skid_hit;
  logic [WIDTH-1:0] cap_val, skid_fwd;

  // wb_hit already excludes address 0, so x0 can never be forwarded here.
  assign cap_hit  = wb_hit && (wb_addr == rd_addr);
  assign main_hit = wb_hit && (wb_addr == main_addr);
  assign skid_hit = wb_hit && (wb_addr == skid_addr);

  assign cap_val  = cap_hit  ? wb_data : rd_data;
  // The skid word moving into main must not miss a writeback on that edge.
  assign skid_fwd = skid_hit ? wb_data : skid_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      main_addr <= '0;
      main_q    <= '0;
    end else if (load_main) begin
      main_addr <= rd_addr;
      main_q    <= cap_val;
    end else if (copy_skid) begin
      main_addr <= skid_addr;
      main_q    <= skid_fwd;
    end else if (main_vld && main_hit) begin
      main_q    <= wb_data;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      skid_addr <= '0;
      skid_q    <= '0;
    end else if (load_skid) begin
      skid_addr <= rd_addr;
      skid_q    <= cap_val;
    end else if (skid_vld && skid_hit) begin
      skid_q    <= wb_data;
    end
  end

  assign main_data = main_q;

endmodule

// ---------------------------------------------------------------------------
// operand_stage top
// ---------------------------------------------------------------------------
module operand_stage #(
  parameter int WIDTH = 32,
  parameter int NCH   = 2,
  parameter int AW    = 5
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*AW-1:0]  rd_addr,
  input  logic [NCH*WIDTH-1:0] rd_data,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_addr,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [15:0]        stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;

  // Handshake outputs are pure state decodes so they carry no input paths.
  assign out_valid = (state == ONE) || (state == TWO);
  assign in_ready  = (state == EMPTY) || (state == ONE);

  logic in_fire, out_fire;
  logic acc, pop;

  assign in_fire  = in_valid  && in_ready;
  assign out_fire = out_valid && out_ready;

  // Flush overrides both handshakes: nothing is loaded, nothing is popped.
  assign acc = in_fire  && !flush;
  assign pop = out_fire && !flush;

  logic load_main, load_skid, copy_skid;
  logic main_vld, skid_vld, wb_hit;

  assign load_main = ((state == EMPTY) && acc) || ((state == ONE) && acc && pop);
  assign load_skid = (state == ONE) && acc && !pop;
  assign copy_skid = (state == TWO) && pop;
  assign main_vld  = (state != EMPTY);
  assign skid_vld  = (state == TWO);
  assign wb_hit    = wb_en && (wb_addr != '0);

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY:   if (acc) state <= ONE;
        ONE:     if (acc && !pop) state <= TWO;
                 else if (!acc && pop) state <= EMPTY;
        TWO:     if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Stall counter counts through flush; it only reflects output backpressure.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  // Per-channel storage
  logic [NCH-1:0][WIDTH-1:0] main_data_l;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    operand_lane #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_lane (
      .CLK       (CLK),
      .reset     (reset),
      .load_main (load_main),
      .load_skid (load_skid),
      .copy_skid (copy_skid),
      .main_vld  (main_vld),
      .skid_vld  (skid_vld),
      .rd_addr   (rd_addr[k*AW +: AW]),
      .rd_data   (rd_data[k*WIDTH +: WIDTH]),
      .wb_hit    (wb_hit),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .main_data (main_data_l[k])
    );
  end

  assign out_data = main_data_l;

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage
//   Scoreboard bench for operand_stage. A behavioural model keeps the held
//   sets in a queue in arrival order, applies writebacks to every queued set,
//   and predicts out_valid, in_ready, out_data and stall_cnt each cycle.
module tb_operand_stage;

  localparam int W = 32;
  localparam int N = 2;
  localparam int A = 5;

  logic             CLK = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [N*A-1:0]   rd_addr;
  logic [N*W-1:0]   rd_data;
  logic             wb_en;
  logic [A-1:0]     wb_addr;
  logic [W-1:0]     wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_data;
  logic [15:0]      stall_cnt;

  operand_stage #(.WIDTH(W), .NCH(N), .AW(A)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N*A-1:0] a;
    logic [N*W-1:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] stall_m;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Check at negedge, then advance the model across the rising edge.
  task automatic step();
    logic vld, ofire, ifire;
    ent_t e;
    @(negedge CLK);
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
    if (q.size() != 0) chk("out_data", out_data, q[0].d);
    chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, stall_m});
    vld   = (q.size() != 0);
    ofire = vld && out_ready;
    ifire = in_valid && (q.size() < 2);
    @(posedge CLK);
    if (vld && !out_ready && stall_m != 16'hFFFF) stall_m++;
    if (flush) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        for (int k = 0; k < N; k++)
          if (wb_en && wb_addr != 0 && e.a[k*A +: A] == wb_addr) e.d[k*W +: W] = wb_data;
        q[i] = e;
      end
      if (ifire) begin
        e.a = rd_addr;
        e.d = rd_data;
        for (int k = 0; k < N; k++)
          if (wb_en && wb_addr != 0 && rd_addr[k*A +: A] == wb_addr) e.d[k*W +: W] = wb_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic send(input logic [A-1:0] a1, input logic [A-1:0] a0,
                      input logic [W-1:0] d1, input logic [W-1:0] d0);
    in_valid = 1'b1;
    rd_addr  = {a1, a0};
    rd_data  = {d1, d0};
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; rd_addr = '0; rd_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    stall_m = '0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_stall",     {48'd0, stall_cnt}, 64'd0);
    chk("rst_out_data",  out_data,           64'd0);
    @(negedge CLK); reset = 1'b1;
    @(posedge CLK); #1;

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid = 1'b1;
    rd_addr = {5'd2, 5'd1}; rd_data = {32'd2, 32'd1}; step();
    chk("stream0", out_data, {32'd2, 32'd1});
    rd_addr = {5'd4, 5'd3}; rd_data = {32'd4, 32'd3}; step();
    chk("stream1", out_data, {32'd4, 32'd3});
    rd_addr = {5'd6, 5'd5}; rd_data = {32'd6, 32'd5}; step();
    chk("stream2", out_data, {32'd6, 32'd5});
    in_valid = 1'b0;
    step(); step();

    // Backpressure: two sets held, then drained in order
    out_ready = 1'b0;
    send(5'd11, 5'd10, 32'hB, 32'hA);
    send(5'd13, 5'd12, 32'hD, 32'hC);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    step(); step();
    chk("bp_head", out_data, {32'hB, 32'hA});
    out_ready = 1'b1;
    step();
    chk("bp_second", out_data, {32'hD, 32'hC});
    step(); step();

    // Capture forwarding on channel 1
    out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h99;
    send(5'd7, 5'd3, 32'h22, 32'h11);
    wb_en = 1'b0;
    chk("cap_fwd", out_data, {32'h99, 32'h11});
    out_ready = 1'b1; step(); step();

    // Held forwarding, x0 never forwarded
    out_ready = 1'b0;
    send(5'd0, 5'd5, 32'h22, 32'h11);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAB; step();
    wb_addr = 5'd0; wb_data = 32'hCD; step();
    wb_en = 1'b0;
    chk("held_fwd", out_data, {32'h22, 32'hAB});

    // Flush from TWO
    send(5'd9, 5'd8, 32'h88, 32'h77);
    chk("two_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_empty", {63'd0, out_valid}, 64'd0);
    step();

    // Reset asserted mid-stream
    out_ready = 1'b0;
    send(5'd2, 5'd1, 32'h5, 32'h6);
    send(5'd4, 5'd3, 32'h7, 32'h8);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready},  64'd1);
    chk("mid_rst_stall", {48'd0, stall_cnt}, 64'd0);
    q.delete(); stall_m = '0;
    @(posedge CLK); @(negedge CLK); reset = 1'b1;
    @(posedge CLK); #1;
    step();

    // Stall counter saturation
    out_ready = 1'b0;
    send(5'd1, 5'd1, 32'h1, 32'h1);
    for (int i = 0; i < 70000; i++) @(posedge CLK);
    #1;
    stall_m = 16'hFFFF;
    chk("stall_sat", {48'd0, stall_cnt}, 64'h0000_0000_0000_FFFF);
    step(); step();
    out_ready = 1'b1; step(); step();

    // Random traffic with writebacks into a small address range
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      rd_addr   = {A'($urandom_range(0, 7)), A'($urandom_range(0, 7))};
      rd_data   = {$urandom, $urandom};
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_addr   = A'($urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, operand data width.
- NCH, 2, number of operand channels.
- AW, 5, register address width.
REQ-002 Ports SHALL be, one per line:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream operand set valid.
- in_ready  out  1  stage can accept an operand set.
- rd_addr  in  NCH*AW  source register address per channel; channel k at bits [k*AW +: AW].
- rd_data  in  NCH*WIDTH  register-file read data per channel; channel k at bits [k*WIDTH +: WIDTH].
- wb_en  in  1  writeback valid.
- wb_addr  in  AW  writeback register address.
- wb_data  in  WIDTH  writeback data.
- out_valid  out  1  operand set presented.
- out_ready  in  1  downstream accepts.
- out_data  out  NCH*WIDTH  held operands, same packing as rd_data.
- stall_cnt  out  16  saturating count of downstream stall cycles.

Function
REQ-003 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-004 Storage SHALL be two entries, main and skid; each entry holds NCH addresses and NCH data words.
REQ-005 The FSM SHALL have three states: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
REQ-006 out_valid SHALL be 1 in states ONE and TWO; in_ready SHALL be 1 in states EMPTY and ONE; both SHALL be pure decodes of the state register.
REQ-007 EMPTY: in_fire SHALL load main and go to ONE; otherwise stay in EMPTY.
REQ-008 ONE: in_fire & !out_fire SHALL load skid and go to TWO.
REQ-009 ONE: !in_fire & out_fire SHALL go to EMPTY.
REQ-010 ONE: in_fire & out_fire SHALL load main and stay in ONE.
REQ-011 TWO: out_fire SHALL copy skid into main and go to ONE; otherwise stay in TWO.
REQ-012 out_data SHALL equal main data; operand sets SHALL leave the stage in arrival order, with no loss or duplication.
REQ-013 Capture forwarding: when loading channel k, if wb_en=1, wb_addr==rd_addr[k] and wb_addr!=0, wb_data SHALL be stored instead of rd_data[k].
REQ-014 Held forwarding: each cycle, every valid entry channel that is not being overwritten and whose stored address equals wb_addr (wb_en=1, wb_addr!=0) SHALL take wb_data.
REQ-015 Held forwarding SHALL apply to the skid value being copied into main on that edge.
REQ-016 Address 0 SHALL never be forwarded.
REQ-017 flush=1 SHALL force the state to EMPTY on the next edge and override in_fire and out_fire.
REQ-018 On flush, stored data need not be cleared.
REQ-019 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, and saturate at 16'hFFFF.
REQ-020 stall_cnt SHALL be unaffected by flush.
REQ-021 Latency SHALL be one cycle: an operand set accepted on edge N is presented on out_data after edge N.
REQ-022 Throughput SHALL be one set per cycle while out_ready=1.

Reset
REQ-023 reset=0 SHALL immediately, independent of CLK, set the state to EMPTY and clear all entry data, all entry addresses and stall_cnt to 0.
REQ-024 While reset=0, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-025 Reset asserted mid-transfer SHALL discard all held sets; the first edge after release SHALL behave as state EMPTY.

Verification
REQ-026 Streaming: NCH=2, out_ready=1, send sets {1,2},{3,4},{5,6} on consecutive cycles -> out_data shows the same sequence one cycle later, in_ready stays 1.
REQ-027 Backpressure: out_ready=0, send {A,B} then {C,D} -> state TWO, in_ready=0; raise out_ready -> {A,B} then {C,D} with no loss; stall_cnt counts the stalled cycles.
REQ-028 Capture forward: rd_addr={3,7}, rd_data={0x11,0x22}, wb_en=1, wb_addr=7, wb_data=0x99 in the same cycle -> out_data={0x11,0x99}.
REQ-029 Held forward and x0: while stalled holding addr {5,0}, apply writebacks to 5 (0xAB) and to 0 (0xCD) -> channel 0 becomes 0xAB, channel 1 unchanged.
REQ-030 Flush and reset: in state TWO assert flush -> EMPTY next cycle, out_valid=0.
REQ-031 Reset mid-stream: assert reset mid-stream -> out_valid=0 and stall_cnt=0 immediately.
REQ-032 Saturation: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF.
